// File: rtl/reg_dump_reader_if.sv
// Byte stream from the register dump reader to the debug UART transmitter.
// The master drives data/valid; the slave drives ready.
interface reg_dump_reader_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register file through its second read-select port and streams every register MSB-first.
// Define REG_DUMP_CHECKSUM_EN to append an 8-bit XOR checksum byte after the last register.
module reg_dump_reader #(
    parameter int NB_DATA = 32,
    parameter int N_REGS  = 32,
    parameter int NB_SEL  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    output logic [NB_SEL-1:0]  o_rd_sel,
    input  logic [NB_DATA-1:0] i_rd_data,
    reg_dump_reader_if.master  tx,
    output logic               o_busy,
    output logic               o_done
);
    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_BYTES - 1);
    localparam logic [NB_SEL-1:0] LAST_REG  = NB_SEL'(N_REGS - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SEND = 3'd2;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam logic [2:0] CSUM = 3'd3;
`endif
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]         state;
    logic [NB_SEL-1:0]  idx;
    logic [NB_CNT-1:0]  byte_cnt;
    logic [NB_DATA-1:0] shift;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    // Index is held in a register so the read select is stable across LOAD.
    assign o_rd_sel = idx;
    assign o_busy   = (state != IDLE);
    assign o_done   = (state == DONE);

    // Valid decodes straight from state so reset drops it asynchronously.
    always_comb begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = '0;
        case (state)
            SEND: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = shift[NB_DATA-1 -: 8];
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = csum;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            byte_cnt <= '0;
            shift    <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        idx      <= '0;
                        byte_cnt <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum     <= '0;
`endif
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    shift <= i_rd_data;
                    state <= SEND;
                end
                SEND: begin
                    if (tx.tx_ready) begin
                        shift <= shift << 8;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum  <= csum ^ shift[NB_DATA-1 -: 8];
`endif
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            if (idx == LAST_REG) begin
`ifdef REG_DUMP_CHECKSUM_EN
                                state <= CSUM;
`else
                                state <= DONE;
`endif
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= LOAD;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (tx.tx_ready) state <= DONE;
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: reset, full dump, backpressure, start while busy,
// reset mid-dump and (with REG_DUMP_CHECKSUM_EN) the checksum byte.
module tb_reg_dump_reader;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NBYTES = 4 * 32 + CS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;

    logic [7:0] byte_q [$];
    int done_cnt;
    int done_cyc;
    int hold_err;
    int timed_out;

    reg_dump_reader_if tx_if ();

    reg_dump_reader #(.NB_DATA(32), .N_REGS(32), .NB_SEL(5)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (i_start),
        .o_rd_sel  (rd_sel),
        .i_rd_data (rd_data),
        .tx        (tx_if),
        .o_busy    (busy),
        .o_done    (done)
    );

    always #5 clk = ~clk;
    assign rd_data = regs[rd_sel];

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        logic [7:0]  c;
        if (i >= 128) begin
            c = 8'h00;
            for (int k = 0; k < 128; k++) c = c ^ exp_byte_data(k);
            return c;
        end
        w = regs[i / 4];
        return w[31 - 8 * (i % 4) -: 8];
    endfunction

    function automatic logic [7:0] exp_byte_data(input int i);
        logic [31:0] w;
        w = regs[i / 4];
        return w[31 - 8 * (i % 4) -: 8];
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if ((cyc >= 40 && cyc < 60) || (cyc >= 300 && cyc < 320)) return 1'b0;
        return 1'(($urandom_range(0, 2) != 0));
    endfunction

    // Runs one dump from posedge+1 alignment; i_start is sampled at the following edge (cycle 1).
    task automatic run_dump(input int mode, input int busy_start_byte, input int max_cycles);
        int  cyc;
        bit  prev_stall;
        bit  pulsed;
        logic [7:0] prev_data;
        byte_q.delete();
        done_cnt = 0; done_cyc = -1; hold_err = 0; timed_out = 0;
        prev_stall = 0; prev_data = '0; pulsed = 0;
        i_start = 1'b1;
        tx_if.tx_ready = ready_for(mode, 0);
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 1;
        tx_if.tx_ready = ready_for(mode, cyc);
        while (cyc < max_cycles) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (prev_stall && (!tx_if.tx_valid || tx_if.tx_data != prev_data)) hold_err++;
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_data  = tx_if.tx_data;
            if (tx_if.tx_valid && tx_if.tx_ready) byte_q.push_back(tx_if.tx_data);
            if (done_cyc >= 0 && cyc >= done_cyc + 20) break;
            @(posedge clk); #1;
            cyc++;
            tx_if.tx_ready = ready_for(mode, cyc);
            i_start = 1'b0;
            if (busy_start_byte > 0 && !pulsed && byte_q.size() == busy_start_byte) begin
                i_start = 1'b1;
                pulsed  = 1;
            end
        end
        if (done_cyc < 0) timed_out = 1;
        i_start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; tx_if.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tx_if.tx_valid); end
        checks++; if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", tx_if.tx_data); end
        checks++; if (rd_sel !== 5'd0) begin errors++; $display("FAIL reset_rd_sel got %0d want 0", rd_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        i_start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL start_in_reset busy=%b valid=%b want 0 0", busy, tx_if.tx_valid); end
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL idle_after_release busy=%b valid=%b want 0 0", busy, tx_if.tx_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_dump();
        for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + k;
        regs[0] = 32'h0;
        run_dump(0, 0, 400);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL full_timeout got %0d want 0", timed_out); end
        checks++; if (byte_q.size() != NBYTES) begin errors++; $display("FAIL full_count got %0d want %0d", byte_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < byte_q.size(); i++) begin
            checks++;
            if (byte_q[i] !== exp_byte(i)) begin errors++; $display("FAIL full_byte[%0d] got %h want %h", i, byte_q[i], exp_byte(i)); end
        end
        checks++; if (done_cyc != 161 + CS) begin errors++; $display("FAIL full_done_cycle got %0d want %0d", done_cyc, 161 + CS); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_pulses got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        run_dump(1, 0, 3000);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL bp_timeout got %0d want 0", timed_out); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL bp_hold_violations got %0d want 0", hold_err); end
        checks++; if (byte_q.size() != NBYTES) begin errors++; $display("FAIL bp_count got %0d want %0d", byte_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < byte_q.size(); i++) begin
            checks++;
            if (byte_q[i] !== exp_byte(i)) begin errors++; $display("FAIL bp_byte[%0d] got %h want %h", i, byte_q[i], exp_byte(i)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_pulses got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        run_dump(0, 37, 400);
        checks++; if (byte_q.size() != NBYTES) begin errors++; $display("FAIL busy_start_count got %0d want %0d", byte_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < byte_q.size(); i++) begin
            checks++;
            if (byte_q[i] !== exp_byte(i)) begin errors++; $display("FAIL busy_start_byte[%0d] got %h want %h", i, byte_q[i], exp_byte(i)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done_pulses got %0d want 1", done_cnt); end
        checks++; if (done_cyc != 161 + CS) begin errors++; $display("FAIL busy_start_done_cycle got %0d want %0d", done_cyc, 161 + CS); end
    endtask

    task automatic test_reset_mid_dump();
        int cyc = 0;
        bit reached = 0;
        int dn = 0;
        byte_q.delete();
        tx_if.tx_ready = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        while (cyc < 400 && !reached) begin
            @(negedge clk);
            if (done) dn++;
            if (tx_if.tx_valid && tx_if.tx_ready) byte_q.push_back(tx_if.tx_data);
            @(posedge clk); #1;
            cyc++;
            if (byte_q.size() == 50) reached = 1;
        end
        checks++; if (!reached) begin errors++; $display("FAIL mid_reset_reach got %0d bytes want 50", byte_q.size()); end
        checks++; if (tx_if.tx_valid !== 1'b1 || rd_sel !== 5'd12) begin errors++; $display("FAIL mid_reset_pre valid=%b sel=%0d want 1 12", tx_if.tx_valid, rd_sel); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", tx_if.tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL mid_reset_done_pulses got %0d want 0", dn); end
        @(posedge clk); #1;
        run_dump(0, 0, 400);
        checks++; if (byte_q.size() != NBYTES) begin errors++; $display("FAIL restart_count got %0d want %0d", byte_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < byte_q.size(); i++) begin
            checks++;
            if (byte_q[i] !== exp_byte(i)) begin errors++; $display("FAIL restart_byte[%0d] got %h want %h", i, byte_q[i], exp_byte(i)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", done_cnt); end
    endtask

`ifdef REG_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 32; k++) regs[k] = 32'hA5A5_A5A5;
        regs[0] = 32'h0;
        run_dump(0, 0, 400);
        checks++; if (byte_q.size() != 129) begin errors++; $display("FAIL csum_a5_count got %0d want 129", byte_q.size()); end
        else begin
            checks++; if (byte_q[128] !== 8'h00) begin errors++; $display("FAIL csum_a5 got %h want 00", byte_q[128]); end
        end
        for (int k = 0; k < 32; k++) regs[k] = 32'h0;
        regs[1] = 32'h0000_00FF;
        run_dump(0, 0, 400);
        checks++; if (byte_q.size() != 129) begin errors++; $display("FAIL csum_ff_count got %0d want 129", byte_q.size()); end
        else begin
            checks++; if (byte_q[128] !== 8'hFF) begin errors++; $display("FAIL csum_ff got %h want ff", byte_q[128]); end
        end
        checks++; if (done_cyc != 162) begin errors++; $display("FAIL csum_done_cycle got %0d want 162", done_cyc); end
    endtask
`endif

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = 32'h0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_dump();
`ifdef REG_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
